// File: rtl/regwb_pkg.sv
// Shared constants and write-request payload for the register-file writeback front end.
package regwb_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 2 ** AW;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regwb_scoreboard_if.sv
// Decode, ALU, MDU and register-file write signals of the writeback scoreboard.
interface regwb_scoreboard_if;
    import regwb_pkg::*;

    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          issue_ready;

    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;

    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;

    logic          w_enable;
    logic [AW-1:0] w_addr1;
    logic [DW-1:0] w_data1;

    logic [AW-1:0] r_addr1;
    logic [AW-1:0] r_addr2;
    logic          hazard1;
    logic          hazard2;
    logic          wb_err;

    modport master (
        output issue_valid, issue_addr, alu_valid, alu_addr, alu_data,
               mdu_valid, mdu_addr, mdu_data, r_addr1, r_addr2,
        input  issue_ready, mdu_ready, w_enable, w_addr1, w_data1,
               hazard1, hazard2, wb_err
    );

    modport slave (
        input  issue_valid, issue_addr, alu_valid, alu_addr, alu_data,
               mdu_valid, mdu_addr, mdu_data, r_addr1, r_addr2,
        output issue_ready, mdu_ready, w_enable, w_addr1, w_data1,
               hazard1, hazard2, wb_err
    );

endinterface

// File: rtl/regwb_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  wb_req_t i_push_data,
    input  logic    i_pop,
    output wb_req_t o_head_c,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    wb_req_t       r_mem [DEPTH];

    logic          w_do_push;
    logic          w_do_pop;
    logic [CW-1:0] w_count_nxt;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_do_push   = i_push & (~r_full | i_pop);
    assign w_do_pop    = i_pop & ~r_empty;
    assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/regwb_scoreboard.sv
// Merges ALU and MDU results onto the register-file write port and tracks pending writes.
module regwb_scoreboard
    import regwb_pkg::*;
#(
    parameter int unsigned MDU_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regwb_scoreboard_if.slave bus
);

    logic [NREGS-1:0] r_pending;
    logic             r_w_enable;
    logic [AW-1:0]    r_w_addr;
    logic [DW-1:0]    r_w_data;
    logic             r_wb_err;

    wb_req_t          w_alu_req;
    wb_req_t          w_mdu_req;
    wb_req_t          w_fifo_head;
    wb_req_t          w_sel_req;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_mdu_push;
    logic             w_mdu_pop;
    logic             w_alu_sel;
    logic             w_sel_valid;
    logic             w_sel_pending;
    logic             w_issue_ready;
    logic             w_issue_fire;
    logic [NREGS-1:0] w_pending_nxt;

    assign w_alu_req = {bus.alu_addr, bus.alu_data};
    assign w_mdu_req = {bus.mdu_addr, bus.mdu_data};

    // Address-0 MDU results are accepted for flow control but never stored.
    assign w_mdu_push = bus.mdu_valid & ~w_fifo_full & (bus.mdu_addr != REG_ZERO);

    regwb_fifo #(
        .DEPTH (MDU_DEPTH)
    ) u_mdu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_mdu_push),
        .i_push_data (w_mdu_req),
        .i_pop       (w_mdu_pop),
        .o_head_c    (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_issue_ready = (bus.issue_addr == REG_ZERO) | ~r_pending[bus.issue_addr];
    assign w_issue_fire  = bus.issue_valid & w_issue_ready & (bus.issue_addr != REG_ZERO);
    assign w_alu_sel     = bus.alu_valid & (bus.alu_addr != REG_ZERO);

    // Strict priority: ALU first, then the MDU queue head.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_req   = w_alu_req;
        w_mdu_pop   = 1'b0;
        if (w_alu_sel) begin
            w_sel_valid = 1'b1;
        end else if (!w_fifo_empty) begin
            w_sel_valid = 1'b1;
            w_sel_req   = w_fifo_head;
            w_mdu_pop   = 1'b1;
        end
    end

    // A bit being cleared by the write currently on the port no longer counts as pending.
    assign w_sel_pending = r_pending[w_sel_req.addr]
                         & ~(r_w_enable & (r_w_addr == w_sel_req.addr));

    always_comb begin
        w_pending_nxt = r_pending;
        if (r_w_enable)   w_pending_nxt[r_w_addr]       = 1'b0;
        if (w_issue_fire) w_pending_nxt[bus.issue_addr] = 1'b1;
        w_pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_w_enable <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_w_enable <= w_sel_valid;
            if (w_sel_valid) begin
                r_w_addr <= w_sel_req.addr;
                r_w_data <= w_sel_req.data;
            end
            if (w_sel_valid && !w_sel_pending) r_wb_err <= 1'b1;
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.mdu_ready   = ~w_fifo_full;
    assign bus.w_enable    = r_w_enable;
    assign bus.w_addr1     = r_w_addr;
    assign bus.w_data1     = r_w_data;
    assign bus.wb_err      = r_wb_err;
    assign bus.hazard1     = (bus.r_addr1 != REG_ZERO) & r_pending[bus.r_addr1];
    assign bus.hazard2     = (bus.r_addr2 != REG_ZERO) & r_pending[bus.r_addr2];

endmodule
